// File: rtl/set_assoc_dcache.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU replacement for the MEM stage.
// Define CACHE_STATS_EN to add saturating hit/miss/write-back counter outputs.
module set_assoc_dcache #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 8,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         cpu_read,
  input  logic                                         cpu_write,
  input  logic [ADDR_W-1:0]                            cpu_addr,
  input  logic [DATA_W-1:0]                            cpu_wdata,
  output logic [DATA_W-1:0]                            cpu_rdata,
  output logic                                         cpu_busy,
  output logic                                         mem_read,
  output logic                                         mem_write,
  output logic [ADDR_W-$clog2(4*BLOCK_WORDS)-1:0]      mem_addr,
  output logic [DATA_W*BLOCK_WORDS-1:0]                mem_wdata,
  input  logic [DATA_W*BLOCK_WORDS-1:0]                mem_rdata,
  input  logic                                         mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                                  hit_count,
  output logic [31:0]                                  miss_count,
  output logic [31:0]                                  writeback_count
`endif
);

  localparam int unsigned OFF_W   = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W   = $clog2(SETS);
  localparam int unsigned AGE_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned MADDR_W = ADDR_W - OFF_W - 2;
  localparam int unsigned TAG_W   = MADDR_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] data_q  [SETS][WAYS][BLOCK_WORDS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];
  logic [AGE_W-1:0]  victim_q;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              addr_unused;

  logic              req_c;
  logic              hit_c;
  logic [AGE_W-1:0]  hit_way_c;
  logic [AGE_W-1:0]  victim_c;
  logic              victim_found_c;
  logic              idle_hit_c;
  logic              idle_miss_c;
  logic              fill_c;
  logic              lru_upd_c;
  logic [AGE_W-1:0]  lru_way_c;
  logic [AGE_W-1:0]  age_upd_c [WAYS];

  assign req_off     = cpu_addr[OFF_W+1:2];
  assign req_idx     = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag     = cpu_addr[ADDR_W-1:OFF_W+IDX_W+2];
  assign addr_unused = ^cpu_addr[1:0];

  assign req_c       = cpu_read | cpu_write;
  assign idle_hit_c  = (state_q == S_IDLE) && req_c && hit_c;
  assign idle_miss_c = (state_q == S_IDLE) && req_c && !hit_c;
  assign fill_c      = (state_q == S_ALLOCATE) && mem_ready;
  assign lru_upd_c   = idle_hit_c | fill_c;
  assign lru_way_c   = idle_hit_c ? hit_way_c : victim_q;

  // Parallel tag compare across all ways of the indexed set
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_c     = 1'b1;
        hit_way_c = AGE_W'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the least recently used way
  always_comb begin
    victim_c       = '0;
    victim_found_c = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!victim_found_c && !valid_q[req_idx][w]) begin
        victim_c       = AGE_W'(w);
        victim_found_c = 1'b1;
      end
    end
    if (!victim_found_c) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        if (age_q[req_idx][w] == AGE_W'(WAYS - 1)) begin
          victim_c = AGE_W'(w);
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < int'(WAYS); w++) begin
      age_upd_c[w] = age_q[req_idx][w];
      if (age_q[req_idx][w] < age_q[req_idx][lru_way_c]) begin
        age_upd_c[w] = age_q[req_idx][w] + 1'b1;
      end
    end
    age_upd_c[lru_way_c] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and memory handshake; busy is forced low while reset is asserted
  always_comb begin
    state_d   = state_q;
    cpu_busy  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = {req_tag, req_idx};
    unique case (state_q)
      S_IDLE: begin
        if (idle_miss_c) begin
          cpu_busy = 1'b1;
          if (valid_q[req_idx][victim_c] && dirty_q[req_idx][victim_c]) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        cpu_busy  = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {tag_q[req_idx][victim_q], req_idx};
        if (mem_ready) begin
          state_d = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        cpu_busy = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!reset_n) begin
      cpu_busy = 1'b0;
    end
  end

  always_comb begin
    cpu_rdata = '0;
    if (idle_hit_c) begin
      cpu_rdata = data_q[req_idx][hit_way_c][req_off];
    end
  end

  always_comb begin
    mem_wdata = '0;
    for (int k = 0; k < int'(BLOCK_WORDS); k++) begin
      mem_wdata[k*DATA_W +: DATA_W] = data_q[req_idx][victim_q][k];
    end
  end

  // Line status and LRU ages; cleared by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      victim_q <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) begin
          age_q[s][w] <= AGE_W'(w);
        end
      end
    end else begin
      if (idle_miss_c) begin
        victim_q <= victim_c;
      end
      if (idle_hit_c && cpu_write) begin
        dirty_q[req_idx][hit_way_c] <= 1'b1;
      end
      if (fill_c) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
      end
      if (lru_upd_c) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          age_q[req_idx][w] <= age_upd_c[w];
        end
      end
    end
  end

  // Data and tag storage survive reset; validity alone gates their use
  always_ff @(posedge clk) begin
    if (idle_hit_c && cpu_write) begin
      data_q[req_idx][hit_way_c][req_off] <= cpu_wdata;
    end
    if (fill_c) begin
      tag_q[req_idx][victim_q] <= req_tag;
      for (int k = 0; k < int'(BLOCK_WORDS); k++) begin
        data_q[req_idx][victim_q][k] <= mem_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic        refill_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic [31:0] wb_cnt_q;

  // The re-hit in the cycle right after a fill belongs to the miss, not to the hit count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      refill_q <= fill_c;
      if (idle_hit_c && !refill_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (idle_miss_c && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if ((state_q == S_WRITEBACK) && mem_ready && (wb_cnt_q != 32'hFFFF_FFFF)) begin
        wb_cnt_q <= wb_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count       = hit_cnt_q;
  assign miss_count      = miss_cnt_q;
  assign writeback_count = wb_cnt_q;
`endif

endmodule

// File: tb/tb_set_assoc_dcache.sv
// Directed plus randomized bench for set_assoc_dcache against an LRU-list reference model of the cache and memory.
module tb_set_assoc_dcache;

  localparam int unsigned WAYS = 2;

  logic         clk;
  logic         reset_n;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_busy;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  logic [31:0]  writeback_count;
`endif

  set_assoc_dcache #(
    .ADDR_W(32), .DATA_W(32), .WAYS(WAYS), .SETS(8), .BLOCK_WORDS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: each set is a list of resident lines, most recently used first
  typedef struct packed {
    logic [24:0]  tag;
    logic         dirty;
    logic [127:0] data;
  } line_t;

  line_t        sets_m [8][$];
  logic [127:0] mem_m [logic [27:0]];
  int           m_hit, m_miss, m_wb;

  function automatic logic [127:0] mem_get(input logic [27:0] b);
    logic [127:0] blk;
    if (!mem_m.exists(b)) begin
      for (int w = 0; w < 4; w++) begin
        blk[32*w +: 32] = (32'({b, 2'(w), 2'b00}) * 32'h9E37_79B1) ^ 32'h1234_5678;
      end
      mem_m[b] = blk;
    end
    return mem_m[b];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) sets_m[s].delete();
    m_hit  = 0;
    m_miss = 0;
    m_wb   = 0;
  endtask

  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input int dly, input logic spur);
    logic [2:0]   idx;
    logic [24:0]  tg;
    logic [1:0]   off;
    logic [27:0]  baddr;
    logic [31:0]  exp_rd;
    logic [127:0] fill_blk;
    line_t        ln;
    line_t        vic;
    int           pos;
    bit           hit;
    bit           wb;
    idx   = a[6:4];
    tg    = a[31:7];
    off   = a[3:2];
    baddr = a[31:4];
    pos   = -1;
    for (int i = 0; i < sets_m[idx].size(); i++) if (sets_m[idx][i].tag == tg) pos = i;
    hit = (pos >= 0);
    wb  = 1'b0;
    vic = '0;
    if (hit) begin
      ln = sets_m[idx][pos];
      sets_m[idx].delete(pos);
      m_hit++;
    end else begin
      m_miss++;
      if (sets_m[idx].size() == int'(WAYS)) begin
        vic = sets_m[idx].pop_back();
        wb  = vic.dirty;
        if (wb) begin
          mem_m[{vic.tag, idx}] = vic.data;
          m_wb++;
        end
      end
      ln.tag   = tg;
      ln.dirty = 1'b0;
      ln.data  = mem_get(baddr);
    end
    fill_blk = ln.data;
    exp_rd   = ln.data[32*off +: 32];
    if (w) begin
      ln.data[32*off +: 32] = wd;
      ln.dirty = 1'b1;
    end
    sets_m[idx].push_front(ln);

    @(negedge clk);
    cpu_read  = !w;
    cpu_write = w;
    cpu_addr  = a;
    cpu_wdata = wd;
    mem_ready = spur;
    #1;
    if (hit) begin
      chk("hit_busy", cpu_busy, 0);
      chk("hit_memrw", {mem_read, mem_write}, 0);
      if (!w) chk("hit_rdata", cpu_rdata, exp_rd);
    end else begin
      chk("miss_busy", cpu_busy, 1);
      chk("miss_idle_memrw", {mem_read, mem_write}, 0);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (wb) begin
        chk("wb_memrw", {mem_read, mem_write}, 2'b01);
        chk("wb_addr", mem_addr, {vic.tag, idx});
        chk("wb_data", mem_wdata, vic.data);
        repeat (dly) begin
          @(negedge clk);
          #1;
          chk("wb_hold", {mem_read, mem_write, mem_addr}, {2'b01, vic.tag, idx});
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
      end
      chk("alloc_memrw", {mem_read, mem_write}, 2'b10);
      chk("alloc_addr", mem_addr, baddr);
      chk("alloc_busy", cpu_busy, 1);
      repeat (dly) begin
        @(negedge clk);
        #1;
        chk("alloc_hold", {cpu_busy, mem_read, mem_write, mem_addr}, {3'b110, baddr});
      end
      mem_rdata = fill_blk;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("refill_busy", cpu_busy, 0);
      chk("refill_memrw", {mem_read, mem_write}, 0);
      if (!w) chk("refill_rdata", cpu_rdata, exp_rd);
    end
    @(negedge clk);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic chk_stats();
`ifdef CACHE_STATS_EN
    #1;
    chk("hit_count", hit_count, 32'(m_hit));
    chk("miss_count", miss_count, 32'(m_miss));
    chk("writeback_count", writeback_count, 32'(m_wb));
`endif
  endtask

  initial begin
    logic [31:0] a;
    reset_n   = 1'b0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", cpu_busy, 0);
    chk("rst_memrw", {mem_read, mem_write}, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk_stats();
    @(negedge clk);
    reset_n = 1'b1;

    // Cold read, write hit, read-back
    access(32'h0000_0040, 1'b0, 32'h0, 1, 1'b0);
    access(32'h0000_0044, 1'b1, 32'hDEAD_BEEF, 0, 1'b1);
    access(32'h0000_0044, 1'b0, 32'h0, 0, 1'b0);
    // Dirty 0x040 is LRU after 0x0C0 fill, so 0x140 forces write-back of block 0x4
    access(32'h0000_00C0, 1'b0, 32'h0, 2, 1'b1);
    access(32'h0000_0140, 1'b0, 32'h0, 0, 1'b0);
    chk_stats();

    // Reset in the middle of ALLOCATE abandons the fetch
    @(negedge clk);
    cpu_read = 1'b1;
    cpu_addr = 32'h0000_0300;
    #1;
    chk("r5_miss_busy", cpu_busy, 1);
    @(negedge clk);
    #1;
    chk("r5_alloc", {mem_read, mem_write}, 2'b10);
    reset_n = 1'b0;
    #1;
    chk("r5_rst_memrw", {mem_read, mem_write}, 0);
    chk("r5_rst_busy", cpu_busy, 0);
    chk("r5_rst_rdata", cpu_rdata, 0);
    @(negedge clk);
    cpu_read = 1'b0;
    reset_n  = 1'b1;
    model_reset();
    access(32'h0000_0300, 1'b0, 32'h0, 0, 1'b0);

    // LRU victim choice with clean lines
    access(32'h0000_0040, 1'b0, 32'h0, 0, 1'b0);
    access(32'h0000_00C0, 1'b0, 32'h0, 1, 1'b0);
    access(32'h0000_0040, 1'b0, 32'h0, 0, 1'b0);
    access(32'h0000_0140, 1'b0, 32'h0, 0, 1'b0);
    access(32'h0000_0040, 1'b0, 32'h0, 0, 1'b0);
    access(32'h0000_00C0, 1'b0, 32'h0, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, 5)) << 7;
      a = a | (32'($urandom_range(0, 1)) << 4) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | 32'h8000_0000;
      access(a, ($urandom_range(0, 2) == 0), $urandom, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
    end
    chk_stats();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
